// File: rtl/udma_hyper_cfg_pkg.sv
// Purpose: shared types and register map for the HyperBus channel config master.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package udma_hyper_cfg_pkg;

    // One queued configuration access.
    typedef struct packed {
        logic        rwn;
        logic [4:0]  addr;
        logic [31:0] data;
    } cfg_cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } cfg_state_e;

    // Per-channel configuration register word addresses.
    localparam logic [4:0] PAGE_BOUND        = 5'h00;
    localparam logic [4:0] T_LATENCY_ACCESS  = 5'h01;
    localparam logic [4:0] EN_LATENCY_ADD    = 5'h02;
    localparam logic [4:0] T_CS_MAX          = 5'h03;
    localparam logic [4:0] T_RW_RECOVERY     = 5'h04;
    localparam logic [4:0] T_RWDS_DELAY_LINE = 5'h05;
    localparam logic [4:0] T_VARI_LATENCY    = 5'h06;
    localparam logic [4:0] N_HYPER_DEVICE    = 5'h07;
    localparam logic [4:0] MEM_SEL           = 5'h08;
    localparam logic [4:0] TRANS_ID_ALLOC    = 5'h09;

endpackage

// File: rtl/udma_hyper_cfg_cmd_fifo.sv
// Purpose: synchronous command FIFO of cfg_cmd_t with flush.
// Latency: a push is visible on pop_dat / empty after one edge; no fall-through.
// Backpressure: full blocks pushes; clear drops a same-cycle push and blocks pop.
//
// Ports: clk_i, rst_ni; clear (flush pointers/count); push_vld/push_dat (write side);
//        pop/pop_dat (read side, pop_dat shows the head entry); full, empty (registered count).
module udma_hyper_cfg_cmd_fifo
    import udma_hyper_cfg_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     clear,
    input  logic     push_vld,
    input  cfg_cmd_t push_dat,
    input  logic     pop,
    output cfg_cmd_t pop_dat,
    output logic     full,
    output logic     empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    cfg_cmd_t      mem_q [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [AW:0]   cnt_q;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push_vld & ~full & ~clear;
    assign do_pop  = pop & ~empty & ~clear;
    assign pop_dat = mem_q[rptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else if (clear) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            // Pointers are exactly log2(DEPTH) bits, so they wrap on their own.
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only read when the count says they are valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= push_dat;
    end

endmodule

// File: rtl/udma_hyper_cfg_master.sv
// Purpose: queues config read/write commands and issues them one at a time on the cfg bus.
// Latency: cmd accepted at edge k -> cfg_valid_o after k+1 -> rsp_valid_o after k+2 (cfg_ready_i=1).
// Backpressure: cmd_ready_o low while the FIFO is full; rsp_valid_o holds until rsp_ready_i.
//
// Ports: clk_i/rst_ni; clear_i flushes queued commands; cmd_* command input (valid/ready);
//        cfg_* request toward the register file (cfg_ready_i completes it, cfg_data_i returns
//        read data); rsp_* one response per command (data, timeout error); busy_o activity flag.
module udma_hyper_cfg_master
    import udma_hyper_cfg_pkg::*;
#(
    parameter int unsigned CMD_DEPTH      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned ADDR_W         = 5
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_rwn_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [31:0]       cmd_data_i,
    output logic              cfg_valid_o,
    output logic              cfg_rwn_o,
    output logic [ADDR_W-1:0] cfg_addr_o,
    output logic [31:0]       cfg_data_o,
    input  logic [31:0]       cfg_data_i,
    input  logic              cfg_ready_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [31:0]       rsp_data_o,
    output logic              rsp_err_o,
    output logic              busy_o
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    cfg_state_e    state_q, state_d;
    cfg_cmd_t      push_cmd;
    cfg_cmd_t      head_cmd;
    cfg_cmd_t      req_q;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_pop;
    logic [TW-1:0] to_cnt_q;
    logic          timeout_hit;
    logic [31:0]   rsp_data_q;
    logic          rsp_err_q;

    assign push_cmd = '{rwn: cmd_rwn_i, addr: 5'(cmd_addr_i), data: cmd_data_i};

    udma_hyper_cfg_cmd_fifo #(
        .DEPTH (CMD_DEPTH)
    ) i_cmd_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear    (clear_i),
        .push_vld (cmd_valid_i),
        .push_dat (push_cmd),
        .pop      (fifo_pop),
        .pop_dat  (head_cmd),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // A value of zero disables the timeout entirely.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (to_cnt_q == TO_LAST);

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next state. A flush in the same cycle wins over the IDLE pop, so the head entry
    // is discarded rather than issued.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!fifo_empty && !clear_i)        state_d = ISSUE;
            ISSUE:   if (cfg_ready_i || timeout_hit)     state_d = RESP;
            RESP:    if (rsp_ready_i)                    state_d = IDLE;
            default:                                     state_d = IDLE;
        endcase
    end

    // Outputs decoded from state.
    always_comb begin
        cfg_valid_o = (state_q == ISSUE);
        rsp_valid_o = (state_q == RESP);
        fifo_pop    = (state_q == IDLE) && !fifo_empty && !clear_i;
        busy_o      = (state_q != IDLE) || !fifo_empty;
    end

    // Request/response holding registers and the ISSUE wait counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_q      <= '0;
            to_cnt_q   <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            if (fifo_pop) begin
                req_q.rwn  <= head_cmd.rwn;
                req_q.addr <= head_cmd.addr;
                // Reads drive zero write data so the responder never sees stale payload.
                req_q.data <= head_cmd.rwn ? 32'h0 : head_cmd.data;
                to_cnt_q   <= '0;
            end
            if (state_q == ISSUE) begin
                if (cfg_ready_i) begin
                    rsp_data_q <= req_q.rwn ? cfg_data_i : 32'h0;
                    rsp_err_q  <= 1'b0;
                end else if (timeout_hit) begin
                    rsp_data_q <= 32'h0;
                    rsp_err_q  <= 1'b1;
                end else begin
                    to_cnt_q <= to_cnt_q + 1'b1;
                end
            end
        end
    end

    assign cmd_ready_o = ~fifo_full;
    assign cfg_rwn_o   = req_q.rwn;
    assign cfg_addr_o  = ADDR_W'(req_q.addr);
    assign cfg_data_o  = req_q.data;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_udma_hyper_cfg_master.sv
// Purpose: self-checking bench for udma_hyper_cfg_master against a transaction-level model.
// Latency: n/a.
// Backpressure: randomised cfg_ready_i / rsp_ready_i plus directed stall cases.
module tb_udma_hyper_cfg_master;

    localparam int DEPTH = 4;
    localparam int TO    = 16;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        clear_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_rwn_i;
    logic [4:0]  cmd_addr_i;
    logic [31:0] cmd_data_i;
    logic        cfg_valid_o;
    logic        cfg_rwn_o;
    logic [4:0]  cfg_addr_o;
    logic [31:0] cfg_data_o;
    logic [31:0] cfg_data_i;
    logic        cfg_ready_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_data_o;
    logic        rsp_err_o;
    logic        busy_o;

    always #5 clk_i = ~clk_i;

    udma_hyper_cfg_master #(
        .CMD_DEPTH      (DEPTH),
        .TIMEOUT_CYCLES (TO),
        .ADDR_W         (5)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (clear_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_rwn_i   (cmd_rwn_i),
        .cmd_addr_i  (cmd_addr_i),
        .cmd_data_i  (cmd_data_i),
        .cfg_valid_o (cfg_valid_o),
        .cfg_rwn_o   (cfg_rwn_o),
        .cfg_addr_o  (cfg_addr_o),
        .cfg_data_o  (cfg_data_o),
        .cfg_data_i  (cfg_data_i),
        .cfg_ready_i (cfg_ready_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_data_o  (rsp_data_o),
        .rsp_err_o   (rsp_err_o),
        .busy_o      (busy_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Transaction model: commands waiting in the queue, the one being issued,
    // the response owed, and the register file the responder serves.
    typedef struct {
        bit        rwn;
        bit [4:0]  addr;
        bit [31:0] data;
    } tcmd_t;

    tcmd_t     q[$];
    tcmd_t     cur;
    bit        req_act;
    bit        rsp_pend;
    int        waitc;
    bit [31:0] e_data;
    bit        e_err;
    bit [31:0] regs[32];
    int        n_rsp = 0;
    bit [31:0] last_rsp;
    bit        last_err;

    task automatic model_reset();
        q.delete();
        req_act  = 0;
        rsp_pend = 0;
        waitc    = 0;
    endtask

    // One clock cycle, entered and left at a falling edge: check what the DUT shows,
    // drive the inputs for the next rising edge, and advance the model across that edge.
    task automatic step(input bit cv, input bit rwn, input bit [4:0] a, input bit [31:0] d,
                        input bit crdy, input bit rrdy, input bit clr);
        bit push_ok;
        chk("cmd_rdy", cmd_ready_o, q.size() < DEPTH);
        chk("busy", busy_o, (q.size() != 0) || req_act || rsp_pend);
        chk("cfg_vld", cfg_valid_o, req_act);
        if (req_act) begin
            chk("cfg_rwn", cfg_rwn_o, cur.rwn);
            chk("cfg_addr", cfg_addr_o, cur.addr);
            chk("cfg_dat", cfg_data_o, cur.rwn ? 32'h0 : cur.data);
        end
        chk("rsp_vld", rsp_valid_o, rsp_pend);
        if (rsp_pend) begin
            chk("rsp_dat", rsp_data_o, e_data);
            chk("rsp_err", rsp_err_o, e_err);
        end
        if (rsp_valid_o && rrdy) begin
            n_rsp++;
            last_rsp = rsp_data_o;
            last_err = rsp_err_o;
        end

        cmd_valid_i = cv;
        cmd_rwn_i   = rwn;
        cmd_addr_i  = a;
        cmd_data_i  = d;
        cfg_ready_i = crdy;
        rsp_ready_i = rrdy;
        clear_i     = clr;
        cfg_data_i  = (req_act && crdy) ? regs[cur.addr] : $urandom;

        push_ok = cv && !clr && (q.size() < DEPTH);
        if (req_act) begin
            if (crdy) begin
                e_data = cur.rwn ? regs[cur.addr] : 32'h0;
                e_err  = 0;
                if (!cur.rwn) regs[cur.addr] = cur.data;
                req_act  = 0;
                rsp_pend = 1;
            end else begin
                waitc++;
                if (waitc == TO) begin
                    e_data   = 32'h0;
                    e_err    = 1;
                    req_act  = 0;
                    rsp_pend = 1;
                end
            end
        end else if (rsp_pend) begin
            if (rrdy) rsp_pend = 0;
        end else if (q.size() != 0 && !clr) begin
            cur     = q.pop_front();
            req_act = 1;
            waitc   = 0;
        end
        if (clr) q.delete();
        if (push_ok) q.push_back('{rwn, a, d});

        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic idle(input int n, input bit crdy, input bit rrdy);
        for (int i = 0; i < n; i++) step(0, 0, 5'd0, 32'h0, crdy, rrdy, 0);
    endtask

    initial begin
        int base;
        int vcnt;

        rst_ni      = 1'b0;
        clear_i     = 1'b0;
        cmd_valid_i = 1'b0;
        cmd_rwn_i   = 1'b0;
        cmd_addr_i  = '0;
        cmd_data_i  = '0;
        cfg_data_i  = '0;
        cfg_ready_i = 1'b0;
        rsp_ready_i = 1'b0;
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        model_reset();

        repeat (2) @(negedge clk_i);
        chk("rst_cfg_vld", cfg_valid_o, 0);
        chk("rst_rsp_vld", rsp_valid_o, 0);
        chk("rst_cmd_rdy", cmd_ready_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_rsp_dat", rsp_data_o, 0);
        chk("rst_rsp_err", rsp_err_o, 0);
        chk("rst_cfg_dat", cfg_data_o, 0);
        chk("rst_cfg_addr", cfg_addr_o, 0);
        chk("rst_cfg_rwn", cfg_rwn_o, 0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Write 0x3 to PAGE_BOUND.
        base = n_rsp;
        step(1, 0, 5'h00, 32'h3, 1, 1, 0);
        idle(4, 1, 1);
        chk("wr_nrsp", n_rsp - base, 1);
        chk("wr_rsp_dat", last_rsp, 0);
        chk("wr_rsp_err", last_err, 0);

        // Read T_CS_MAX while the responder returns 665.
        regs[3] = 32'd665;
        base = n_rsp;
        step(1, 1, 5'h03, $urandom, 1, 1, 0);
        idle(4, 1, 1);
        chk("rd_nrsp", n_rsp - base, 1);
        chk("rd_rsp_dat", last_rsp, 32'h299);
        chk("rd_rsp_err", last_err, 0);

        // Responder never ready: request must time out after 16 cycles.
        vcnt = 0;
        step(1, 1, 5'h07, 32'h0, 0, 1, 0);
        for (int i = 0; i < 25; i++) begin
            if (cfg_valid_o) vcnt++;
            step(0, 0, 5'd0, 32'h0, 0, 1, 0);
        end
        chk("to_len", vcnt, TO);
        chk("to_err", last_err, 1);
        chk("to_dat", last_rsp, 0);

        // Five back-to-back commands with responses blocked: 4 queued + 1 in flight.
        base = n_rsp;
        for (int i = 0; i < 5; i++) step(1, 1'($urandom), 5'($urandom_range(0, 9)), $urandom, 1, 0, 0);
        chk("full_rdy", cmd_ready_o, 0);
        for (int i = 0; i < 24; i++) step(0, 0, 5'd0, 32'h0, 1, (i % 3) == 2, 0);
        chk("full_nrsp", n_rsp - base, 5);

        // Flush with three queued and one in ISSUE: only the in-flight one answers.
        base = n_rsp;
        for (int i = 0; i < 4; i++) step(1, 0, 5'(i + 1), $urandom, 0, 1, 0);
        step(0, 0, 5'd0, 32'h0, 0, 1, 1);
        idle(8, 1, 1);
        chk("clr_nrsp", n_rsp - base, 1);
        chk("clr_busy", busy_o, 0);

        // Reset asserted while a request is in ISSUE.
        step(1, 0, 5'h02, $urandom, 0, 1, 0);
        step(0, 0, 5'd0, 32'h0, 0, 1, 0);
        chk("pre_rst_vld", cfg_valid_o, 1);
        rst_ni = 1'b0;
        #1;
        chk("rst_mid_vld", cfg_valid_o, 0);
        chk("rst_mid_rsp", rsp_valid_o, 0);
        model_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("post_rst_busy", busy_o, 0);
        chk("post_rst_rdy", cmd_ready_o, 1);

        // Random traffic with a forced responder stall window to provoke timeouts.
        for (int i = 0; i < 900; i++) begin
            bit crdy;
            crdy = (i >= 400 && i < 440) ? 1'b0 : ($urandom_range(0, 9) < 7);
            step($urandom_range(0, 2) != 0, 1'($urandom), 5'($urandom_range(0, 12)), $urandom,
                 crdy, $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
        end
        idle(40, 1, 1);
        chk("drain_busy", busy_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
